// File: rtl/controle_vagas.sv
// Companion controller for the parking-gate FSM: tracks vehicles through the
// entry sensor pair and the exit sensor, keeps the occupancy count, and runs the password timeout.
module controle_vagas #(
    parameter int MAX_VAGAS = 8,
    parameter int W_VAGAS   = 4,
    parameter int TIMEOUT   = 50,
    parameter int W_TIMER   = 6
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               SE,
    input  logic               SI,
    input  logic               SS,
    input  logic               Gatilho,
    input  logic               Senha,
    output logic [W_VAGAS-1:0] Vagas,
    output logic               Full,
    output logic               Time,
    output logic               Erro
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] A    = 2'd1;
    localparam logic [1:0] AB   = 2'd2;
    localparam logic [1:0] B    = 2'd3;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [W_VAGAS-1:0] VAGAS_MAX  = W_VAGAS'(MAX_VAGAS);
    localparam logic [W_VAGAS-1:0] VAGAS_ONE  = W_VAGAS'(1);
    localparam logic [W_TIMER-1:0] TIMER_LAST = W_TIMER'(TIMEOUT - 1);
    localparam logic [W_TIMER-1:0] TIMER_ONE  = W_TIMER'(1);

    logic [1:0]         entryState;
    logic [1:0]         entryNext;
    logic               inc;
    logic               dec;
    logic               ssPrev;
    logic [W_VAGAS-1:0] vagasNext;
    logic               erroNext;

    logic [1:0]         timerState;
    logic [1:0]         timerNext;
    logic [W_TIMER-1:0] cnt;
    logic [W_TIMER-1:0] cntNext;
    logic               timeNext;

    // A vehicle must cover SE, then both, then only SI, then clear SI to count as an entry.
    always_comb begin
        entryNext = entryState;
        inc       = 1'b0;
        case (entryState)
            IDLE: begin
                if (SE && !SI)
                    entryNext = A;
            end
            A: begin
                if (SE && SI)
                    entryNext = AB;
                else if (!SE && !SI)
                    entryNext = IDLE;
            end
            AB: begin
                if (!SE && SI)
                    entryNext = B;
                else if (SE && !SI)
                    entryNext = A;
                else if (!SE && !SI)
                    entryNext = IDLE;
            end
            B: begin
                if (!SI) begin
                    entryNext = IDLE;
                    inc       = 1'b1;
                end else if (SE) begin
                    entryNext = AB;
                end
            end
            default: entryNext = IDLE;
        endcase
    end

    assign dec = SS & ~ssPrev;

    always_comb begin
        vagasNext = Vagas;
        erroNext  = 1'b0;
        if (inc && !dec) begin
            if (Vagas == VAGAS_MAX)
                erroNext = 1'b1;
            else
                vagasNext = Vagas + VAGAS_ONE;
        end else if (dec && !inc) begin
            if (Vagas == '0)
                erroNext = 1'b1;
            else
                vagasNext = Vagas - VAGAS_ONE;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            entryState <= IDLE;
            ssPrev     <= 1'b0;
            Vagas      <= '0;
            Full       <= 1'b0;
            Erro       <= 1'b0;
        end else begin
            entryState <= entryNext;
            ssPrev     <= SS;
            Vagas      <= vagasNext;
            Full       <= (vagasNext == VAGAS_MAX);
            Erro       <= erroNext;
        end
    end

    // Dropping Gatilho always wins, then Senha, then the timeout itself.
    always_comb begin
        timerNext = timerState;
        cntNext   = cnt;
        timeNext  = 1'b0;
        case (timerState)
            T_IDLE: begin
                cntNext = '0;
                if (Gatilho)
                    timerNext = RUN;
            end
            RUN: begin
                if (!Gatilho) begin
                    timerNext = T_IDLE;
                    cntNext   = '0;
                end else if (Senha) begin
                    timerNext = DONE;
                    cntNext   = '0;
                end else if (cnt == TIMER_LAST) begin
                    timerNext = EXPIRED;
                    cntNext   = '0;
                    timeNext  = 1'b1;
                end else begin
                    cntNext = cnt + TIMER_ONE;
                end
            end
            EXPIRED, DONE: begin
                cntNext = '0;
                if (!Gatilho)
                    timerNext = T_IDLE;
            end
            default: begin
                timerNext = T_IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            timerState <= T_IDLE;
            cnt        <= '0;
            Time       <= 1'b0;
        end else begin
            timerState <= timerNext;
            cnt        <= cntNext;
            Time       <= timeNext;
        end
    end

endmodule

// File: tb/tb_controle_vagas.sv
// Scoreboard bench for controle_vagas: a driver pushes the model's expected outputs per edge,
// a monitor pops and compares them shortly after each rising edge.
module tb_controle_vagas;

    localparam int MAX_VAGAS = 8;
    localparam int W_VAGAS   = 4;
    localparam int TIMEOUT   = 50;
    localparam int W_TIMER   = 6;

    typedef struct packed {
        logic [W_VAGAS-1:0] vagas;
        logic               full;
        logic               tout;
        logic               erro;
    } expect_t;

    logic               CLK = 1'b0;
    logic               reset = 1'b0;
    logic               SE = 1'b0;
    logic               SI = 1'b0;
    logic               SS = 1'b0;
    logic               Gatilho = 1'b0;
    logic               Senha = 1'b0;
    logic [W_VAGAS-1:0] Vagas;
    logic               Full;
    logic               Time;
    logic               Erro;

    expect_t scoreQ[$];
    int checks = 0;
    int failures = 0;

    int pos = 0;
    int occupancy = 0;
    bit ssSeen = 0;
    bit timerRunning = 0;
    bit timerBlocked = 0;
    int startEdge = 0;
    int edgeNum = 0;

    controle_vagas #(
        .MAX_VAGAS(MAX_VAGAS), .W_VAGAS(W_VAGAS), .TIMEOUT(TIMEOUT), .W_TIMER(W_TIMER)
    ) dut (
        .CLK(CLK), .reset(reset), .SE(SE), .SI(SI), .SS(SS),
        .Gatilho(Gatilho), .Senha(Senha),
        .Vagas(Vagas), .Full(Full), .Time(Time), .Erro(Erro)
    );

    always #5 CLK = ~CLK;

    // Reference: vehicle position (0 none, 1 on outer, 2 straddling, 3 on inner only),
    // an occupancy integer, and a timestamp-based timeout.
    function automatic expect_t modelEdge(bit se, bit si, bit ss, bit g, bit pw);
        expect_t e;
        bit entered;
        bit left;
        bit errFlag;
        bit pulse;
        entered = 0;
        errFlag = 0;
        pulse   = 0;
        case (pos)
            0: if (se && !si) pos = 1;
            1: if (se && si) pos = 2; else if (!se && !si) pos = 0;
            2: if (!se && si) pos = 3; else if (se && !si) pos = 1; else if (!se && !si) pos = 0;
            default: if (!si) begin pos = 0; entered = 1; end else if (se) pos = 2;
        endcase
        left   = ss && !ssSeen;
        ssSeen = ss;
        if (entered && !left) begin
            if (occupancy == MAX_VAGAS) errFlag = 1; else occupancy++;
        end else if (left && !entered) begin
            if (occupancy == 0) errFlag = 1; else occupancy--;
        end
        if (timerRunning) begin
            if (!g) timerRunning = 0;
            else if (pw) begin timerRunning = 0; timerBlocked = 1; end
            else if (edgeNum - startEdge == TIMEOUT) begin
                pulse = 1; timerRunning = 0; timerBlocked = 1;
            end
        end else if (timerBlocked) begin
            if (!g) timerBlocked = 0;
        end else if (g) begin
            timerRunning = 1;
            startEdge = edgeNum;
        end
        edgeNum++;
        e.vagas = W_VAGAS'(occupancy);
        e.full  = (occupancy == MAX_VAGAS);
        e.tout  = pulse;
        e.erro  = errFlag;
        return e;
    endfunction

    task automatic applyStimulus(input bit se, input bit si, input bit ss,
                                 input bit g, input bit pw, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            reset = 1'b1;
            SE = se; SI = si; SS = ss; Gatilho = g; Senha = pw;
            scoreQ.push_back(modelEdge(se, si, ss, g, pw));
        end
    endtask

    task automatic applyReset(input int n);
        expect_t z;
        z = '0;
        @(negedge CLK);
        reset = 1'b0;
        pos = 0; occupancy = 0; ssSeen = 0; timerRunning = 0; timerBlocked = 0;
        #1;
        checks++;
        if (dut.cnt !== '0 || Vagas !== '0 || Full !== 1'b0 || Time !== 1'b0 || Erro !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: cnt=%0d Vagas=%0d Full=%b Time=%b Erro=%b required all 0",
                     dut.cnt, Vagas, Full, Time, Erro);
        end
        scoreQ.push_back(z);
        for (int i = 1; i < n; i++) begin
            @(negedge CLK);
            scoreQ.push_back(z);
        end
    endtask

    task automatic doEntry();
        applyStimulus(1, 0, 0, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, 0, 2);
        applyStimulus(0, 1, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 1);
    endtask

    task automatic checkOutput(input expect_t exp);
        checks++;
        if (Vagas !== exp.vagas || Full !== exp.full || Time !== exp.tout || Erro !== exp.erro) begin
            failures++;
            $display("[TB] FAIL outputs@edge%0d: got Vagas=%0d Full=%b Time=%b Erro=%b required Vagas=%0d Full=%b Time=%b Erro=%b",
                     checks, Vagas, Full, Time, Erro, exp.vagas, exp.full, exp.tout, exp.erro);
        end
    endtask

    // Monitor: every rising edge presents a new registered output word.
    always @(posedge CLK) begin
        #1;
        if (scoreQ.size() > 0)
            checkOutput(scoreQ.pop_front());
    end

    initial begin
        int gLeft;
        bit gVal;
        applyReset(3);

        doEntry();
        applyStimulus(1, 0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 2);

        for (int k = 0; k < 8; k++) doEntry();
        doEntry();
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 2);

        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, 1, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 1, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 2);

        applyStimulus(0, 0, 0, 1, 0, 120);
        applyStimulus(0, 0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 1, 0, 60);
        applyStimulus(0, 0, 0, 0, 0, 2);

        applyStimulus(0, 0, 0, 1, 0, 30);
        applyStimulus(0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 60);
        applyStimulus(0, 0, 0, 0, 0, 2);

        applyStimulus(1, 0, 0, 1, 0, 2);
        applyStimulus(1, 1, 0, 1, 0, 18);
        applyReset(3);
        applyStimulus(0, 1, 0, 1, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 60);

        gLeft = 0;
        gVal  = 0;
        for (int k = 0; k < 2500; k++) begin
            if (gLeft == 0) begin
                gVal  = ~gVal;
                gLeft = gVal ? $urandom_range(10, 80) : $urandom_range(1, 6);
            end
            gLeft--;
            if ($urandom_range(0, 400) == 0)
                applyReset(2);
            else
                applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                              ($urandom_range(0, 5) == 0), gVal,
                              ($urandom_range(0, 60) == 0), $urandom_range(1, 3));
        end

        applyStimulus(0, 0, 0, 0, 0, 2);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (scoreQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", scoreQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
